pic_service_ctrl: RTL and testbench
===================================

# pic_service_ctrl

Interrupt service controller for the PIC: sits between the masked request vector from the interrupt request register and the CPU interface. Resolves priority against the in-service register (fully nested mode) and raises INT. Runs the two-pulse INTA handshake, drives the interrupt vector and maintains ISR under normal or automatic EOI. Also returns a one-cycle clear pulse to the request latch for the acknowledged level.

## Interface
Parameters:
- INTA_TIMEOUT, 15: cycles allowed in WAIT2 for the second INTA falling edge before the cycle is aborted; counter width is clog2(INTA_TIMEOUT+1).

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- irr  in  8  masked interrupt requests, bit n = IRn
- vector_base  in  5  vector bits T7..T3, from ICW2
- aeoi  in  1  1 = automatic EOI mode
- eoi_valid  in  1  one-cycle EOI command strobe
- eoi_specific  in  1  1 = specific EOI, 0 = non-specific; qualified by eoi_valid
- eoi_level  in  3  level cleared by a specific EOI
- inta_n  in  1  CPU acknowledge, active-low, synchronous to clk
- int_out  out  1  interrupt request to CPU
- isr  out  8  in-service register
- clr_req  out  8  one-hot, one-cycle clear of the acknowledged request latch
- data_out  out  8  vector {vector_base, level[2:0]}; 0 when data_oe=0
- data_oe  out  1  data bus drive enable

## Operation
- Reset (rst_n=0 at a clock edge), from any state:
  - outputs: int_out=0, isr=0, clr_req=0, data_out=0, data_oe=0
  - internals: state=IDLE, timeout counter=0, latched level=0, inta_n history=1
- Priority: fixed, IR0 highest, IR7 lowest, unless ROTATE_PRIORITY_EN.
- A request is eligible when its priority is strictly higher than the highest-priority set ISR bit; with isr=0, any irr bit is eligible.
- INTA edges: fall = prev_inta_n & ~inta_n; rise = ~prev_inta_n & inta_n. prev_inta_n is the previous cycle's sample.
- FSM states: IDLE, REQ, WAIT2, VEC.
  - IDLE: an eligible request exists → REQ; int_out=1.
  - REQ, eligible request still present, on fall:
    - latch the highest-priority eligible level L
    - set isr[L]; pulse clr_req[L]
    - int_out=0; counter cleared → WAIT2
  - REQ, request withdrawn: int_out=0 and → IDLE.
  - REQ, fall with no eligible request: spurious acknowledge. L=7, no ISR set, no clr_req → WAIT2.
  - WAIT2:
    - fall → VEC: data_oe=1, data_out={vector_base, L}
    - otherwise counter increments; at INTA_TIMEOUT → IDLE with isr[L] cleared, unless spurious
  - VEC, on rise: data_oe=0, data_out=0 → IDLE. If aeoi=1 and not spurious, isr[L] clears on the same edge.
- EOI (eoi_valid=1, any state):
  - non-specific clears the highest-priority set ISR bit
  - specific clears isr[eoi_level]
  - with isr=0 it has no effect
- Simultaneous ISR set and clear on the same edge: the clear is computed from the pre-update ISR, then the set is applied; set wins on the same bit.
- An interrupt of higher priority than an in-service level may re-enter REQ from IDLE (nesting); equal or lower priority waits for EOI.

## Timing
- int_out asserts 1 cycle after an eligible request appears in IDLE.
- On the edge that samples the first fall: isr, clr_req and int_out update, visible the following cycle.
- clr_req is high exactly 1 cycle per acknowledge.
- data_oe/data_out: valid 1 cycle after the second fall is sampled; deassert 1 cycle after the rise is sampled.
- EOI takes effect on the edge sampling eoi_valid; isr updates the next cycle.
- Minimum back-to-back service: IDLE→REQ is possible on the cycle after returning to IDLE.
- inta_n must be pre-synchronised by the bus interface.

## Configuration
- ROTATE_PRIORITY_EN defined: adds a 3-bit lowest-priority pointer, reset value 7.
  - A non-specific EOI sets the pointer to the cleared level, so level pointer+1 (mod 8) becomes highest priority.
  - In aeoi mode the AEOI clear rotates the same way.
  - Specific EOI never rotates.
- Not defined: fixed priority, IR0 highest; no pointer logic.

## Test plan
- irr=0x08, vector_base=0x11, two INTA pulses:
  - int_out=1 on the next cycle
  - after the 1st fall: isr=0x08, clr_req=0x08 for 1 cycle
  - after the 2nd fall: data_out=0x8B, data_oe=1
- isr=0x04, irr=0x10 → int_out stays 0. Then irr=0x02 → int_out=1; after acknowledge isr=0x06.
- irr=0x01 withdrawn to 0x00 before the 1st INTA, INTA pulses anyway → no ISR bit set, no clr_req, data_out={vector_base,3'b111}.
- aeoi=1, acknowledge IR5 → isr[5]=1 during VEC, isr=0 the cycle after inta_n rises. Second INTA withheld for INTA_TIMEOUT cycles → IDLE, isr[5] cleared.
- isr=0x05, non-specific EOI → isr=0x04. Specific EOI level 2 → isr=0x00. rst_n=0 during VEC → all outputs 0 the next cycle.
- ROTATE_PRIORITY_EN defined, isr=0x08, non-specific EOI → isr=0x00 and IR4 becomes highest priority; irr=0x11 then acknowledges IR4.

Source files
------------

// File: rtl/pic_service_ctrl.sv
// PIC interrupt service controller: priority resolution against ISR, INTA handshake, vector drive, EOI/AEOI.
// Optional rotating priority is enabled by defining ROTATE_PRIORITY_EN.
module pic_service_ctrl #(
  parameter int unsigned INTA_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] irr,
  input  logic [4:0] vector_base,
  input  logic       aeoi,
  input  logic       eoi_valid,
  input  logic       eoi_specific,
  input  logic [2:0] eoi_level,
  input  logic       inta_n,
  output logic       int_out,
  output logic [7:0] isr,
  output logic [7:0] clr_req,
  output logic [7:0] data_out,
  output logic       data_oe
);

  localparam int unsigned CW = $clog2(INTA_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(INTA_TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_WAIT2 = 2'd2;
  localparam logic [1:0] ST_VEC   = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] tmo_cnt;
  logic [2:0]    lvl;
  logic          spurious;
  logic          prev_inta_n;
  logic          fall;
  logic          rise;

  // Level currently holding the highest priority
  logic [2:0]    base;

`ifdef ROTATE_PRIORITY_EN
  logic [2:0]    low_ptr;
  assign base = low_ptr + 3'd1;
`else
  assign base = '0;
`endif

  assign fall = prev_inta_n & ~inta_n;
  assign rise = ~prev_inta_n & inta_n;

  logic       isr_any;
  logic [2:0] isr_top_lvl;
  logic [2:0] isr_top_rank;
  logic       req_valid;
  logic [2:0] req_lvl;

  // Scan in priority order; rank r is r steps below the highest-priority level
  always_comb begin
    logic [2:0] l;
    l            = '0;
    isr_any      = 1'b0;
    isr_top_lvl  = '0;
    isr_top_rank = '0;
    req_valid    = 1'b0;
    req_lvl      = '0;
    for (int unsigned r = 0; r < 8; r++) begin
      l = base + 3'(r);
      if (!isr_any && isr[l]) begin
        isr_any      = 1'b1;
        isr_top_lvl  = l;
        isr_top_rank = 3'(r);
      end
    end
    for (int unsigned r = 0; r < 8; r++) begin
      l = base + 3'(r);
      if (!req_valid && irr[l] && (!isr_any || (3'(r) < isr_top_rank))) begin
        req_valid = 1'b1;
        req_lvl   = l;
      end
    end
  end

  logic [7:0] eoi_clr;
  logic [7:0] fsm_clr;
  logic [7:0] set_mask;
  logic       aeoi_rot;

  always_comb begin
    eoi_clr  = '0;
    fsm_clr  = '0;
    set_mask = '0;
    aeoi_rot = 1'b0;
    if (eoi_valid) begin
      if (eoi_specific)
        eoi_clr[eoi_level] = 1'b1;
      else if (isr_any)
        eoi_clr[isr_top_lvl] = 1'b1;
    end
    case (state)
      ST_REQ: begin
        if (fall && req_valid)
          set_mask[req_lvl] = 1'b1;
      end
      ST_WAIT2: begin
        if (!fall && (tmo_cnt == TMO_LAST) && !spurious)
          fsm_clr[lvl] = 1'b1;
      end
      ST_VEC: begin
        if (rise && aeoi && !spurious) begin
          fsm_clr[lvl] = 1'b1;
          aeoi_rot     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Clears act on the pre-update ISR; a set on the same bit wins
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      isr     <= '0;
      clr_req <= '0;
    end else begin
      isr     <= (isr & ~(eoi_clr | fsm_clr)) | set_mask;
      clr_req <= set_mask;
    end
  end

`ifdef ROTATE_PRIORITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      low_ptr <= 3'd7;
    else if (aeoi_rot)
      low_ptr <= lvl;
    else if (eoi_valid && !eoi_specific && isr_any)
      low_ptr <= isr_top_lvl;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      tmo_cnt     <= '0;
      lvl         <= '0;
      spurious    <= 1'b0;
      prev_inta_n <= 1'b1;
      int_out     <= 1'b0;
      data_out    <= '0;
      data_oe     <= 1'b0;
    end else begin
      prev_inta_n <= inta_n;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            state   <= ST_REQ;
            int_out <= 1'b1;
          end
        end
        ST_REQ: begin
          if (fall) begin
            int_out <= 1'b0;
            tmo_cnt <= '0;
            state   <= ST_WAIT2;
            if (req_valid) begin
              lvl      <= req_lvl;
              spurious <= 1'b0;
            end else begin
              lvl      <= 3'd7;
              spurious <= 1'b1;
            end
          end else if (!req_valid) begin
            int_out <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        ST_WAIT2: begin
          if (fall) begin
            state    <= ST_VEC;
            data_oe  <= 1'b1;
            data_out <= {vector_base, lvl};
          end else if (tmo_cnt == TMO_LAST) begin
            state   <= ST_IDLE;
            tmo_cnt <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_VEC: begin
          if (rise) begin
            state    <= ST_IDLE;
            data_oe  <= 1'b0;
            data_out <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pic_service_ctrl.sv
// Directed self-checking bench for pic_service_ctrl (default and ROTATE_PRIORITY_EN builds).
module tb_pic_service_ctrl;

  localparam int unsigned TMO = 15;

  logic       clk;
  logic       rst_n;
  logic [7:0] irr;
  logic [4:0] vector_base;
  logic       aeoi;
  logic       eoi_valid;
  logic       eoi_specific;
  logic [2:0] eoi_level;
  logic       inta_n;
  logic       int_out;
  logic [7:0] isr;
  logic [7:0] clr_req;
  logic [7:0] data_out;
  logic       data_oe;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  pic_service_ctrl #(.INTA_TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .irr          (irr),
    .vector_base  (vector_base),
    .aeoi         (aeoi),
    .eoi_valid    (eoi_valid),
    .eoi_specific (eoi_specific),
    .eoi_level    (eoi_level),
    .inta_n       (inta_n),
    .int_out      (int_out),
    .isr          (isr),
    .clr_req      (clr_req),
    .data_out     (data_out),
    .data_oe      (data_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic eoi(input logic spec, input logic [2:0] level);
    eoi_valid    = 1'b1;
    eoi_specific = spec;
    eoi_level    = level;
    tick();
    eoi_valid    = 1'b0;
  endtask

  task automatic ack(input string tag, input logic [7:0] req, input logic [7:0] exp_isr,
                     input logic [7:0] exp_clr, input logic [7:0] exp_vec);
    irr = req;
    tick();
    check({tag, "_int"}, {7'd0, int_out}, 8'h01);
    inta_n = 1'b0;
    tick();
    check({tag, "_isr"}, isr, exp_isr);
    check({tag, "_clr"}, clr_req, exp_clr);
    irr    = 8'h00;
    inta_n = 1'b1;
    tick();
    check({tag, "_clr_off"}, clr_req, 8'h00);
    inta_n = 1'b0;
    tick();
    check({tag, "_vec"}, data_out, exp_vec);
    check({tag, "_oe"}, {7'd0, data_oe}, 8'h01);
    inta_n = 1'b1;
    tick();
    check({tag, "_oe_off"}, {7'd0, data_oe}, 8'h00);
  endtask

  initial begin
    rst_n = 1'b0; irr = 8'h00; vector_base = 5'h11; aeoi = 1'b0;
    eoi_valid = 1'b0; eoi_specific = 1'b0; eoi_level = 3'd0; inta_n = 1'b1;
    tick(); tick();
    check("rst_int",  {7'd0, int_out}, 8'h00);
    check("rst_isr",  isr, 8'h00);
    check("rst_clr",  clr_req, 8'h00);
    check("rst_data", data_out, 8'h00);
    check("rst_oe",   {7'd0, data_oe}, 8'h00);
    rst_n = 1'b1;

    // Basic IR3 service
    irr = 8'h08;
    tick();
    check("t1_int", {7'd0, int_out}, 8'h01);
    inta_n = 1'b0;
    tick();
    check("t1_isr", isr, 8'h08);
    check("t1_clr", clr_req, 8'h08);
    check("t1_int_off", {7'd0, int_out}, 8'h00);
    irr = 8'h00; inta_n = 1'b1;
    tick();
    check("t1_clr_off", clr_req, 8'h00);
    inta_n = 1'b0;
    tick();
    check("t1_vec", data_out, 8'h8B);
    check("t1_oe", {7'd0, data_oe}, 8'h01);
    inta_n = 1'b1;
    tick();
    check("t1_oe_off", {7'd0, data_oe}, 8'h00);
    check("t1_data_off", data_out, 8'h00);
    check("t1_isr_hold", isr, 8'h08);
    eoi(1'b0, 3'd0);
    check("t1_eoi", isr, 8'h00);
    eoi(1'b0, 3'd0);
    check("t1_eoi_empty", isr, 8'h00);

    // Nesting: lower priority blocked, higher priority nests
    do_reset();
    ack("t2a", 8'h04, 8'h04, 8'h04, 8'h8A);
    irr = 8'h10;
    tick(); tick();
    check("t2_blocked", {7'd0, int_out}, 8'h00);
    ack("t2b", 8'h12, 8'h06, 8'h02, 8'h89);
    eoi(1'b0, 3'd0);
    check("t2_eoi_ns", isr, 8'h04);
    eoi(1'b1, 3'd2);
    check("t2_eoi_sp", isr, 8'h00);

    // Spurious acknowledge: request gone on the first fall
    irr = 8'h01;
    tick();
    check("t3_int", {7'd0, int_out}, 8'h01);
    irr = 8'h00; inta_n = 1'b0;
    tick();
    check("t3_isr", isr, 8'h00);
    check("t3_clr", clr_req, 8'h00);
    check("t3_int_off", {7'd0, int_out}, 8'h00);
    inta_n = 1'b1;
    tick();
    inta_n = 1'b0;
    tick();
    check("t3_vec", data_out, 8'h8F);
    check("t3_oe", {7'd0, data_oe}, 8'h01);
    inta_n = 1'b1;
    tick();
    check("t3_oe_off", {7'd0, data_oe}, 8'h00);

    // AEOI and second-INTA timeout
    do_reset();
    aeoi = 1'b1;
    irr  = 8'h20;
    tick();
    inta_n = 1'b0;
    tick();
    check("t4_isr_set", isr, 8'h20);
    irr = 8'h00; inta_n = 1'b1;
    tick();
    inta_n = 1'b0;
    tick();
    check("t4_isr_vec", isr, 8'h20);
    check("t4_vec", data_out, 8'h8D);
    inta_n = 1'b1;
    tick();
    check("t4_aeoi", isr, 8'h00);
    irr = 8'h20;
    tick();
    inta_n = 1'b0;
    tick();
    check("t4_tmo_set", isr, 8'h20);
    irr = 8'h00; inta_n = 1'b1;
    repeat (3) tick();
    check("t4_tmo_wait", isr, 8'h20);
    repeat (TMO) tick();
    check("t4_tmo_clr", isr, 8'h00);
    check("t4_tmo_oe", {7'd0, data_oe}, 8'h00);
    irr = 8'h01;
    tick();
    check("t4_idle_req", {7'd0, int_out}, 8'h01);
    irr = 8'h00;
    tick();
    check("t4_withdraw", {7'd0, int_out}, 8'h00);
    aeoi = 1'b0;

    // EOI variants and reset during VEC
    do_reset();
    ack("t5a", 8'h04, 8'h04, 8'h04, 8'h8A);
    ack("t5b", 8'h01, 8'h05, 8'h01, 8'h88);
    eoi(1'b0, 3'd0);
    check("t5_eoi_ns", isr, 8'h04);
    eoi(1'b1, 3'd2);
    check("t5_eoi_sp", isr, 8'h00);
    irr = 8'h08;
    tick();
    inta_n = 1'b0;
    tick();
    irr = 8'h00; inta_n = 1'b1;
    tick();
    inta_n = 1'b0;
    tick();
    check("t5_vec_oe", {7'd0, data_oe}, 8'h01);
    rst_n = 1'b0;
    tick();
    check("t5_rst_int",  {7'd0, int_out}, 8'h00);
    check("t5_rst_isr",  isr, 8'h00);
    check("t5_rst_clr",  clr_req, 8'h00);
    check("t5_rst_data", data_out, 8'h00);
    check("t5_rst_oe",   {7'd0, data_oe}, 8'h00);
    rst_n = 1'b1; inta_n = 1'b1;
    tick();
    check("t5_post_oe", {7'd0, data_oe}, 8'h00);

    // Priority after a non-specific EOI of IR3
    ack("t6a", 8'h08, 8'h08, 8'h08, 8'h8B);
    eoi(1'b0, 3'd0);
    check("t6_eoi", isr, 8'h00);
`ifdef ROTATE_PRIORITY_EN
    ack("t6b", 8'h11, 8'h10, 8'h10, 8'h8C);
`else
    ack("t6b", 8'h11, 8'h01, 8'h01, 8'h88);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
